// File: rtl/ifetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller.
package ifetch_pkg;

    localparam int unsigned TIMER_W     = 8;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_HOLD  = 3'd4;
    localparam state_t ST_ERR   = 3'd5;

    // States in which a request is outstanding and the response timer runs.
    function automatic logic is_waiting(input state_t s);
        return (s == ST_WAIT) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/ifetch_timer.sv
// Saturating response timer; o_expired flags that this cycle's count reaches TIMEOUT.
module ifetch_timer
    import ifetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expire on the TIMEOUT-th waiting cycle, not one cycle later.
    assign o_expired = i_enable && (r_count >= (LIMIT - 1'b1));

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding read, flush handling, bus timeout.
// Optional misaligned-fetch trap enabled by defining IFETCH_MISALIGN_EN.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] i_pcAddr,
    input  logic              i_flush,
    input  logic              i_decodeReady,
    output logic              o_memReq,
    output logic [ADDR_W-1:0] o_memAddr,
    input  logic              i_memGnt,
    input  logic              i_memRvalid,
    input  logic [DATA_W-1:0] i_memRdata,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_instrAddr,
    output logic              o_instrValid,
    output logic              o_pcHold,
    output logic              o_busErr,
    output logic              o_misalign
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_addr;
    logic [ADDR_W-1:0] w_aligned;
    logic              w_misaligned;
    logic              w_req_ok;
    logic              w_grant;
    logic              w_expired;

    assign w_aligned = i_pcAddr & ~ADDR_W'(3);

`ifdef IFETCH_MISALIGN_EN
    logic r_misalign;

    assign w_misaligned = (i_pcAddr[1:0] != 2'b00);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_misalign <= 1'b0;
        end else if ((r_state == ST_REQ) && !i_flush && w_misaligned) begin
            r_misalign <= 1'b1;
        end
    end

    assign o_misalign = r_misalign;
`else
    assign w_misaligned = 1'b0;
    assign o_misalign   = 1'b0;
`endif

    // A flush in REQ suppresses the request so the redirected PC is fetched next.
    assign w_req_ok = (r_state == ST_REQ) && !i_flush && !w_misaligned;
    assign w_grant  = w_req_ok && i_memGnt;

    ifetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_clear   (w_grant),
        .i_enable  (is_waiting(r_state)),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (i_flush) begin
                    w_state_nxt = ST_REQ;
                end else if (w_misaligned) begin
                    w_state_nxt = ST_ERR;
                end else if (i_memGnt) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_memRvalid) begin
                    w_state_nxt = i_flush ? ST_REQ : ST_HOLD;
                end else if (w_expired) begin
                    w_state_nxt = ST_ERR;
                end else if (i_flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (i_memRvalid) begin
                    w_state_nxt = ST_REQ;
                end else if (w_expired) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_HOLD: begin
                if (i_flush || i_decodeReady) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= ST_IDLE;
            r_instr      <= '0;
            r_instr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_instr_addr <= i_pcAddr;
            end
            if ((r_state == ST_WAIT) && i_memRvalid && !i_flush) begin
                r_instr <= i_memRdata;
            end
        end
    end

    assign o_memReq     = w_req_ok;
    assign o_memAddr    = (r_state == ST_REQ) ? w_aligned : '0;
    assign o_instr      = r_instr;
    assign o_instrAddr  = r_instr_addr;
    assign o_instrValid = (r_state == ST_HOLD);
    assign o_busErr     = (r_state == ST_ERR);
    assign o_pcHold     = !(((r_state == ST_HOLD) && i_decodeReady) ||
                            (i_flush && ((r_state == ST_REQ) || (r_state == ST_HOLD))));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_ifetch_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic [AW-1:0] pcAddr = '0;
    logic          flush = 1'b0, decodeReady = 1'b0, memGnt = 1'b0, memRvalid = 1'b0;
    logic [DW-1:0] memRdata = '0;
    logic          memReq, instrValid, pcHold, busErr, misalign;
    logic [AW-1:0] memAddr, instrAddr;
    logic [DW-1:0] instr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: request in flight, whether its data is still wanted,
    // instruction on offer, dead after error, cycles already waited.
    bit            m_idle, m_pending, m_keep, m_present, m_dead, m_mis;
    int            m_waited;
    logic [DW-1:0] m_instr;
    logic [AW-1:0] m_addr;

    ifetch_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .i_pcAddr      (pcAddr),
        .i_flush       (flush),
        .i_decodeReady (decodeReady),
        .o_memReq      (memReq),
        .o_memAddr     (memAddr),
        .i_memGnt      (memGnt),
        .i_memRvalid   (memRvalid),
        .i_memRdata    (memRdata),
        .o_instr       (instr),
        .o_instrAddr   (instrAddr),
        .o_instrValid  (instrValid),
        .o_pcHold      (pcHold),
        .o_busErr      (busErr),
        .o_misalign    (misalign)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired: got timeout want finish");
        $fatal(1);
    end

    task automatic model_reset();
        m_idle = 1; m_pending = 0; m_keep = 0; m_present = 0; m_dead = 0; m_mis = 0;
        m_waited = 0; m_instr = '0; m_addr = '0;
    endtask

    function automatic logic pc_misaligned();
`ifdef IFETCH_MISALIGN_EN
        return pcAddr[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        if (!RESET) begin
            model_reset();
        end else if (m_dead) begin
            m_dead = 1;
        end else if (m_idle) begin
            m_idle = 0;
        end else if (m_present) begin
            if (flush || decodeReady) m_present = 0;
        end else if (m_pending) begin
            if (memRvalid) begin
                m_pending = 0;
                if (m_keep && !flush) begin
                    m_present = 1;
                    m_instr   = memRdata;
                end
            end else if (m_waited + 1 >= TO) begin
                m_dead = 1;
            end else begin
                m_waited++;
                if (flush) m_keep = 0;
            end
        end else if (!flush) begin
            if (pc_misaligned()) begin
                m_dead = 1;
                m_mis  = 1;
            end else if (memGnt) begin
                m_pending = 1; m_keep = 1; m_waited = 0; m_addr = pcAddr;
            end
        end
    endtask

    // Advance one clock; inputs change only at the falling edge.
    task automatic cyc();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        RESET = 1'b0; flush = 0; decodeReady = 0; memGnt = 0; memRvalid = 0;
        model_reset();
        cyc(); cyc();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        flush = 1; memGnt = 1; memRvalid = 1; decodeReady = 1; pcAddr = 32'h0000_0104;
        @(negedge CLK); #1;
        n_cmp += 8;
        if (memReq !== 1'b0)     begin n_bad++; $display("FAIL rst_memReq got %b want 0", memReq); end
        if (memAddr !== '0)      begin n_bad++; $display("FAIL rst_memAddr got %h want 0", memAddr); end
        if (instr !== '0)        begin n_bad++; $display("FAIL rst_instr got %h want 0", instr); end
        if (instrAddr !== '0)    begin n_bad++; $display("FAIL rst_instrAddr got %h want 0", instrAddr); end
        if (instrValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", instrValid); end
        if (pcHold !== 1'b1)     begin n_bad++; $display("FAIL rst_pcHold got %b want 1", pcHold); end
        if (busErr !== 1'b0)     begin n_bad++; $display("FAIL rst_busErr got %b want 0", busErr); end
        if (misalign !== 1'b0)   begin n_bad++; $display("FAIL rst_misalign got %b want 0", misalign); end
        apply_reset();
    endtask

    task automatic test_basic();
        pcAddr = 32'h0; memGnt = 1;
        #1;
        n_cmp += 2;
        if (memReq !== 1'b0) begin n_bad++; $display("FAIL idle_memReq got %b want 0", memReq); end
        if (pcHold !== 1'b1) begin n_bad++; $display("FAIL idle_pcHold got %b want 1", pcHold); end
        cyc();
        #1;
        n_cmp += 2;
        if (memReq !== 1'b1)   begin n_bad++; $display("FAIL req_memReq got %b want 1", memReq); end
        if (memAddr !== 32'h0) begin n_bad++; $display("FAIL req_memAddr got %h want 0", memAddr); end
        cyc();
        memGnt = 0; memRvalid = 1; memRdata = 32'h0000_0013;
        #1;
        n_cmp++;
        if (instrValid !== 1'b0) begin n_bad++; $display("FAIL wait_valid got %b want 0", instrValid); end
        cyc();
        memRvalid = 0;
        #1;
        n_cmp += 3;
        if (instrValid !== 1'b1)      begin n_bad++; $display("FAIL lat_valid got %b want 1", instrValid); end
        if (instr !== 32'h13)         begin n_bad++; $display("FAIL lat_instr got %h want 13", instr); end
        if (instrAddr !== 32'h0)      begin n_bad++; $display("FAIL lat_addr got %h want 0", instrAddr); end
    endtask

    task automatic test_hold_stall();
        decodeReady = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp += 3;
            if (pcHold !== 1'b1)     begin n_bad++; $display("FAIL stall_pcHold[%0d] got %b want 1", i, pcHold); end
            if (instrValid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, instrValid); end
            if (instr !== 32'h13)    begin n_bad++; $display("FAIL stall_instr[%0d] got %h want 13", i, instr); end
            cyc();
        end
        decodeReady = 1;
        #1;
        n_cmp++;
        if (pcHold !== 1'b0) begin n_bad++; $display("FAIL accept_pcHold got %b want 0", pcHold); end
        cyc();
        decodeReady = 0;
        #1;
        n_cmp += 2;
        if (pcHold !== 1'b1)     begin n_bad++; $display("FAIL after_pcHold got %b want 1", pcHold); end
        if (instrValid !== 1'b0) begin n_bad++; $display("FAIL after_valid got %b want 0", instrValid); end
    endtask

    task automatic test_flush_wait();
        pcAddr = 32'h100; memGnt = 1;
        #1;
        n_cmp += 2;
        if (memReq !== 1'b1)     begin n_bad++; $display("FAIL fw_memReq got %b want 1", memReq); end
        if (memAddr !== 32'h100) begin n_bad++; $display("FAIL fw_memAddr got %h want 100", memAddr); end
        cyc();
        memGnt = 0; flush = 1;
        #1;
        n_cmp++;
        if (pcHold !== 1'b1) begin n_bad++; $display("FAIL fw_pcHold got %b want 1", pcHold); end
        cyc();
        flush = 0; memRvalid = 1; memRdata = 32'h0000_DEAD; pcAddr = 32'h200;
        #1;
        n_cmp++;
        if (instrValid !== 1'b0) begin n_bad++; $display("FAIL drain_valid got %b want 0", instrValid); end
        cyc();
        memRvalid = 0; memGnt = 1;
        #1;
        n_cmp += 3;
        if (memReq !== 1'b1)     begin n_bad++; $display("FAIL re_memReq got %b want 1", memReq); end
        if (memAddr !== 32'h200) begin n_bad++; $display("FAIL re_memAddr got %h want 200", memAddr); end
        if (instrValid !== 1'b0) begin n_bad++; $display("FAIL stale_valid got %b want 0", instrValid); end
        cyc();
        memGnt = 0; memRvalid = 1; memRdata = 32'h0000_CAFE;
        cyc();
        memRvalid = 0;
        #1;
        n_cmp += 3;
        if (instrValid !== 1'b1)    begin n_bad++; $display("FAIL fw_valid got %b want 1", instrValid); end
        if (instr !== 32'hCAFE)     begin n_bad++; $display("FAIL fw_instr got %h want cafe", instr); end
        if (instrAddr !== 32'h200)  begin n_bad++; $display("FAIL fw_addr got %h want 200", instrAddr); end
        // Flush beats decodeReady in HOLD.
        flush = 1; decodeReady = 1;
        #1;
        n_cmp++;
        if (pcHold !== 1'b0) begin n_bad++; $display("FAIL hflush_pcHold got %b want 0", pcHold); end
        cyc();
        flush = 0; decodeReady = 0;
        #1;
        n_cmp++;
        if (instrValid !== 1'b0) begin n_bad++; $display("FAIL hflush_valid got %b want 0", instrValid); end
    endtask

    task automatic test_timeout();
        pcAddr = 32'h300; memGnt = 1;
        cyc();
        memGnt = 0; memRvalid = 0;
        for (int i = 0; i < TO; i++) begin
            #1;
            n_cmp++;
            if (busErr !== 1'b0) begin n_bad++; $display("FAIL to_early[%0d] got %b want 0", i, busErr); end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            flush = (i == 0); memGnt = 1; memRvalid = 1;
            #1;
            n_cmp += 4;
            if (busErr !== 1'b1)     begin n_bad++; $display("FAIL to_busErr[%0d] got %b want 1", i, busErr); end
            if (memReq !== 1'b0)     begin n_bad++; $display("FAIL to_memReq[%0d] got %b want 0", i, memReq); end
            if (instrValid !== 1'b0) begin n_bad++; $display("FAIL to_valid[%0d] got %b want 0", i, instrValid); end
            if (pcHold !== 1'b1)     begin n_bad++; $display("FAIL to_pcHold[%0d] got %b want 1", i, pcHold); end
            cyc();
        end
    endtask

    task automatic test_misalign();
        apply_reset();
        cyc();
        pcAddr = 32'h102; memGnt = 1;
        #1;
`ifdef IFETCH_MISALIGN_EN
        n_cmp++;
        if (memReq !== 1'b0) begin n_bad++; $display("FAIL mis_memReq got %b want 0", memReq); end
        cyc();
        #1;
        n_cmp += 3;
        if (misalign !== 1'b1) begin n_bad++; $display("FAIL mis_flag got %b want 1", misalign); end
        if (busErr !== 1'b1)   begin n_bad++; $display("FAIL mis_busErr got %b want 1", busErr); end
        if (memReq !== 1'b0)   begin n_bad++; $display("FAIL mis_memReq2 got %b want 0", memReq); end
`else
        n_cmp += 2;
        if (memReq !== 1'b1)     begin n_bad++; $display("FAIL mis_memReq got %b want 1", memReq); end
        if (memAddr !== 32'h100) begin n_bad++; $display("FAIL mis_memAddr got %h want 100", memAddr); end
        cyc();
        #1;
        n_cmp += 2;
        if (misalign !== 1'b0) begin n_bad++; $display("FAIL mis_flag got %b want 0", misalign); end
        if (busErr !== 1'b0)   begin n_bad++; $display("FAIL mis_busErr got %b want 0", busErr); end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cyc();
        pcAddr = 32'h40; memGnt = 1;
        cyc();
        memGnt = 0;
        RESET = 1'b0;
        model_reset();
        #1;
        n_cmp += 6;
        if (memReq !== 1'b0)     begin n_bad++; $display("FAIL rm_memReq got %b want 0", memReq); end
        if (memAddr !== '0)      begin n_bad++; $display("FAIL rm_memAddr got %h want 0", memAddr); end
        if (instrAddr !== '0)    begin n_bad++; $display("FAIL rm_instrAddr got %h want 0", instrAddr); end
        if (instrValid !== 1'b0) begin n_bad++; $display("FAIL rm_valid got %b want 0", instrValid); end
        if (pcHold !== 1'b1)     begin n_bad++; $display("FAIL rm_pcHold got %b want 1", pcHold); end
        if (busErr !== 1'b0)     begin n_bad++; $display("FAIL rm_busErr got %b want 0", busErr); end
        memRvalid = 1; memRdata = 32'h0000_0BAD;
        cyc();
        RESET = 1'b1;
        cyc();
        cyc();
        #1;
        n_cmp += 2;
        if (memReq !== 1'b1)     begin n_bad++; $display("FAIL rm_fresh_req got %b want 1", memReq); end
        if (instrValid !== 1'b0) begin n_bad++; $display("FAIL rm_late_valid got %b want 0", instrValid); end
        memRvalid = 0; memGnt = 1; pcAddr = 32'h44;
        cyc();
        memGnt = 0; memRvalid = 1; memRdata = 32'h0000_1234;
        cyc();
        memRvalid = 0;
        #1;
        n_cmp += 3;
        if (instrValid !== 1'b1)   begin n_bad++; $display("FAIL rm_valid2 got %b want 1", instrValid); end
        if (instr !== 32'h1234)    begin n_bad++; $display("FAIL rm_instr got %h want 1234", instr); end
        if (instrAddr !== 32'h44)  begin n_bad++; $display("FAIL rm_addr got %h want 44", instrAddr); end
    endtask

    task automatic test_random();
        logic          req_phase, e_req, e_hold;
        logic [AW-1:0] e_addr;
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            if (m_dead || ($urandom_range(0, 299) == 0)) begin
                RESET = 1'b0;
                model_reset();
            end else begin
                RESET = 1'b1;
            end
            flush       = ($urandom_range(0, 9) == 0);
            decodeReady = $urandom_range(0, 1) == 1;
            memGnt      = ($urandom_range(0, 9) < 6);
            memRvalid   = ($urandom_range(0, 9) < 7);
            memRdata    = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                pcAddr = ($urandom_range(0, 19) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            end
            #1;
            req_phase = !m_idle && !m_dead && !m_pending && !m_present;
            e_req     = req_phase && !flush && !pc_misaligned();
            e_addr    = req_phase ? (pcAddr & 32'hFFFF_FFFC) : '0;
            e_hold    = !((m_present && decodeReady) || (flush && (req_phase || m_present)));
            n_cmp += 6;
            if (memReq !== e_req)       begin n_bad++; $display("FAIL r_memReq c%0d got %b want %b", c, memReq, e_req); end
            if (memAddr !== e_addr)     begin n_bad++; $display("FAIL r_memAddr c%0d got %h want %h", c, memAddr, e_addr); end
            if (instrValid !== m_present) begin n_bad++; $display("FAIL r_valid c%0d got %b want %b", c, instrValid, m_present); end
            if (pcHold !== e_hold)      begin n_bad++; $display("FAIL r_pcHold c%0d got %b want %b", c, pcHold, e_hold); end
            if (busErr !== m_dead)      begin n_bad++; $display("FAIL r_busErr c%0d got %b want %b", c, busErr, m_dead); end
            if (misalign !== m_mis)     begin n_bad++; $display("FAIL r_misalign c%0d got %b want %b", c, misalign, m_mis); end
            if (m_present) begin
                n_cmp += 2;
                if (instr !== m_instr)    begin n_bad++; $display("FAIL r_instr c%0d got %h want %h", c, instr, m_instr); end
                if (instrAddr !== m_addr) begin n_bad++; $display("FAIL r_addr c%0d got %h want %h", c, instrAddr, m_addr); end
            end
            cyc();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_hold_stall();
        test_flush_wait();
        test_timeout();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
